// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encodings shared by the reset sequencer and other reset users
package reset_sequencer_pkg;
  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_e;
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: soft reset, hold and per-channel reset/ready/stage outputs of the sequencer
interface reset_sequencer_if #(parameter int CHANNELS = 4);
  logic                soft_reset_i;
  logic [CHANNELS-1:0] hold_i;
  logic [CHANNELS-1:0] reset_o;
  logic                ready_o;
  logic [CHANNELS-1:0] stage_o;
  modport master (output soft_reset_i, hold_i, input reset_o, ready_o, stage_o);
  modport slave  (input soft_reset_i, hold_i, output reset_o, ready_o, stage_o);
endinterface

// File: rtl/reset_sequencer_sync.sv
// reset_sequencer_sync: async-assert / sync-deassert synchroniser for the external reset
module reset_sequencer_sync #(parameter int SYNC_STAGES = 2) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign sync_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches reset after power-up/soft reset, then releases channels in index order
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int BITS        = 8,
  parameter int STAGE_GAP   = 16,
  parameter int GAP_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  reset_sequencer_if.slave  bus
);
  localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [BITS-1:0]     CNT_MAX  = '1;
  localparam logic [GAP_BITS-1:0] GAP_DONE = GAP_BITS'(STAGE_GAP - 1);
  localparam logic [IW-1:0]       IDX_LAST = IW'(CHANNELS - 1);

  state_e              state_q, state_d;
  logic [BITS-1:0]     cnt_q, cnt_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CHANNELS-1:0] reset_q, reset_d, stage_q, stage_d;
  logic                ready_q, ready_d;
  logic                run, rel_due;

  reset_sequencer_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sync_o (run)
  );

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      reset_q <= '1;
      stage_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      reset_q <= reset_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    reset_d = reset_q;
    stage_d = stage_q;
    rel_due = 1'b0;
    if (bus.soft_reset_i) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      gap_d   = '0;
      idx_d   = '0;
      reset_d = '1;
      stage_d = '0;
    end else if (run) begin
      case (state_q)
        ST_ASSERT: begin
          cnt_d = cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
          // ch0 releases on the very edge the stretch completes; if held, wait with the gap already expired
          if (cnt_q == CNT_MAX - 1'b1) begin
            state_d = ST_RELEASE;
            gap_d   = GAP_DONE;
            rel_due = 1'b1;
          end
        end
        ST_RELEASE: begin
          gap_d   = gap_q < GAP_DONE ? gap_q + 1'b1 : gap_q;
          rel_due = gap_q == GAP_DONE;
        end
        default: reset_d = bus.hold_i;
      endcase
      if (rel_due && !bus.hold_i[idx_q]) begin
        reset_d[idx_q] = 1'b0;
        stage_d        = '0;
        stage_d[idx_q] = 1'b1;
        gap_d          = '0;
        state_d        = idx_q == IDX_LAST ? ST_RUN : ST_RELEASE;
        idx_d          = idx_q == IDX_LAST ? idx_q : idx_q + 1'b1;
      end
    end
  end

  assign ready_d     = state_d == ST_RUN && reset_d == '0;
  assign bus.reset_o = reset_q;
  assign bus.ready_o = ready_q;
  assign bus.stage_o = stage_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed timing checks of the reset sequencer (3 channels, 4-bit stretch, gap 3)
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  reset_sequencer_if #(.CHANNELS(3)) bus ();

  reset_sequencer #(
    .CHANNELS(3), .BITS(4), .STAGE_GAP(3), .GAP_BITS(8), .SYNC_STAGES(2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    got = {bus.reset_o, bus.ready_o, bus.stage_o};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s reset/ready/stage got=%b_%b_%b exp=%b_%b_%b",
               tag, got[6:4], got[3], got[2:0], exp[6:4], exp[3], exp[2:0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic por();
    rst_n = 1'b0;
    step(5);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.soft_reset_i = 1'b0;
    bus.hold_i = 3'b000;
    // 1: power-on sequence
    step(2);
    chk("t1 in reset", 7'b111_0_000);
    por();
    step(16); chk("t1 e16", 7'b111_0_000);
    step(1);  chk("t1 e17", 7'b110_0_001);
    step(2);  chk("t1 e19", 7'b110_0_001);
    step(1);  chk("t1 e20", 7'b100_0_010);
    step(2);  chk("t1 e22", 7'b100_0_010);
    step(1);  chk("t1 e23", 7'b000_1_100);
    // 2: async abort mid-release, full rerun
    por();
    step(20); chk("t2 e20", 7'b100_0_010);
    #2 rst_n = 1'b0;
    #1 chk("t2 async", 7'b111_0_000);
    #1 rst_n = 1'b1;
    step(16); chk("t2 e16", 7'b111_0_000);
    step(1);  chk("t2 e17", 7'b110_0_001);
    step(6);  chk("t2 e23", 7'b000_1_100);
    // 3: hold ch1 through edges 10..30
    por();
    step(9);  bus.hold_i = 3'b010;
    step(8);  chk("t3 e17", 7'b110_0_001);
    step(13); chk("t3 e30", 7'b110_0_001);
    bus.hold_i = 3'b000;
    step(1);  chk("t3 e31", 7'b100_0_010);
    step(2);  chk("t3 e33", 7'b100_0_010);
    step(1);  chk("t3 e34", 7'b000_1_100);
    // 4: re-hold ch2 in RUN for 4 cycles
    bus.hold_i = 3'b100;
    step(1);  chk("t4 held1", 7'b100_0_100);
    step(3);  chk("t4 held4", 7'b100_0_100);
    bus.hold_i = 3'b000;
    step(1);  chk("t4 drop", 7'b000_1_100);
    // 5: one-cycle soft reset in RUN
    bus.soft_reset_i = 1'b1;
    step(1);  chk("t5 assert", 7'b111_0_000);
    bus.soft_reset_i = 1'b0;
    step(14); chk("t5 +14", 7'b111_0_000);
    step(1);  chk("t5 +15", 7'b110_0_001);
    step(3);  chk("t5 +18", 7'b100_0_010);
    step(3);  chk("t5 +21", 7'b000_1_100);
    // 6: soft reset held 10 cycles with ch0 held during ASSERT
    bus.soft_reset_i = 1'b1;
    step(1);  chk("t6 assert", 7'b111_0_000);
    bus.hold_i = 3'b001;
    step(9);
    bus.soft_reset_i = 1'b0;
    step(14); chk("t6 +14", 7'b111_0_000);
    step(1);  chk("t6 +15 held", 7'b111_0_000);
    step(5);  chk("t6 +20 held", 7'b111_0_000);
    bus.hold_i = 3'b000;
    step(1);  chk("t6 drop", 7'b110_0_001);
    step(3);  chk("t6 ch1", 7'b100_0_010);
    step(3);  chk("t6 ch2", 7'b000_1_100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
